bip_system: RTL
===============

# bip_system

Parametrised BIP processor system with program loading and run/step control. It holds a single-cycle accumulator core, a program memory that can be written through a load port, and a data memory. Execution is gated by a control FSM (idle / run / halt), and an executed-instruction counter is provided. It is the successor of the fixed-program BIP top level and sits directly under board-level glue.

## Interface
- NBITS_O, 11, operand field width (instruction low bits)
- OPCODE, 5, opcode field width (instruction high bits)
- NBITS_D, 16, data/accumulator width; instruction width is OPCODE+NBITS_O and must equal NBITS_D
- PM_CELDAS, 64, program memory words
- DM_CELDAS, 64, data memory words
- NBITS_CNT, 32, executed-instruction counter width
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high
- i_load_en  in  1  write i_load_data into program memory at i_load_addr (IDLE only)
- i_load_addr  in  NBITS_O  program memory write address
- i_load_data  in  NBITS_D  instruction word to write
- i_run  in  1  level-sampled start: IDLE→RUN
- i_step  in  1  execute exactly one instruction while IDLE
- o_halt  out  1  high while in HALT
- o_busy  out  1  high while in RUN
- o_pc  out  NBITS_O  current program counter
- o_acc  out  NBITS_D  accumulator
- o_cycles  out  NBITS_CNT  executed-instruction count

## Operation
- Opcodes: HLT 00000, STO 00001 (DM[op]←ACC), LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, JMP 01000 (PC←op), BEQ 01001 (PC←op if ACC==0), BNE 01010 (PC←op if ACC!=0). Any other opcode is a NOP (PC+1, counted).
- Immediates are sign-extended from NBITS_O to NBITS_D. ADD/SUB wrap modulo 2^NBITS_D, with no flags.
- Memory indices use operand/PC modulo depth (low bits). The PC wraps from PM_CELDAS-1 to 0.
- FSM states:
  - IDLE: accepts loads and steps.
  - RUN: executes one instruction per cycle.
  - HALT: terminal until reset.
- IDLE priority per cycle: i_load_en > i_run > i_step. A load cycle executes nothing. i_run moves to RUN without executing that cycle. i_step executes one instruction and stays IDLE.
- Executing HLT in RUN or step mode: ACC and PC are unchanged, the counter increments, and the state moves to HALT.
- In RUN and HALT, i_load_en, i_run, and i_step are ignored.
- Reset: state IDLE, PC 0, ACC 0, o_cycles 0, o_halt 0, o_busy 0. Memory contents are retained (not cleared). Reset mid-RUN aborts immediately.
- o_cycles saturates at all-ones.

## Timing
- Program memory write is synchronous. Program and data memory reads are combinational (same-cycle fetch/operand read). The data memory write is synchronous on the STO cycle.
- Each instruction commits ACC, PC, DM, and counter on the rising edge of its execute cycle. The result is visible on o_acc and o_pc the next cycle.
- i_run sampled high in cycle N: o_busy=1 from N+1. The first instruction executes in N+1.
- HLT executed in cycle M: o_halt=1 and o_busy=0 from M+1.
- Step sampled in cycle N: the result is visible at N+1, and a new step is accepted at N+1 (holding i_step high steps every cycle).
- A loaded word is fetchable on the cycle after the write.

## Structure
- Package bip_pkg: opcode localparams, state encoding (IDLE/RUN/HALT), and the instruction field-slicing helper.
- One natural sub-module, bip_core: combinational decode plus the ACC/PC update for one instruction, with a fire input. The FSM, counter, and memories live in bip_system.

## Test plan
- Load LDI 5, ADDI 3, STO 2, LD 2, SUBI 10, HLT; pulse i_run → o_halt=1, o_acc=0xFFFE, DM[2]=8, o_cycles=6, o_pc=5.
- Load LDI 3, SUBI 1, BNE 1, HLT; run → o_acc=0, o_pc=3, o_cycles=8. BEQ variant: LDI 0, BEQ 3, LDI 7, HLT → o_acc=0, o_cycles=3.
- Step mode: the first program with two single-cycle i_step pulses → o_acc=8, o_pc=2, o_busy=0, o_halt=0. Then i_run completes to o_acc=0xFFFE.
- i_load_en and i_run high in the same IDLE cycle → the word is written and the state stays IDLE. A load attempted during RUN or HALT → program memory is unchanged.
- Assert i_reset for one cycle mid-RUN of the loop program → next cycle o_pc=0, o_acc=0, o_cycles=0, IDLE. Re-run gives the same results as the uninterrupted run.
- JMP 0 infinite loop, with NBITS_CNT=4 → o_cycles saturates at 15, o_busy stays 1.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor system: opcodes, control states
// and the instruction field-slicing helper.
package bip_pkg;

   localparam logic [7:0] OP_HLT  = 8'h00;
   localparam logic [7:0] OP_STO  = 8'h01;
   localparam logic [7:0] OP_LD   = 8'h02;
   localparam logic [7:0] OP_LDI  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h04;
   localparam logic [7:0] OP_ADDI = 8'h05;
   localparam logic [7:0] OP_SUB  = 8'h06;
   localparam logic [7:0] OP_SUBI = 8'h07;
   localparam logic [7:0] OP_JMP  = 8'h08;
   localparam logic [7:0] OP_BEQ  = 8'h09;
   localparam logic [7:0] OP_BNE  = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_e;

   // Opcode field sits above the operand field; opcode widths up to 8 bits.
   function automatic logic [7:0] op_field(input logic [63:0] instr,
                                           input int unsigned nbits_o,
                                           input int unsigned opcode_w);
      logic [63:0] sh;
      logic [63:0] mask;
      sh   = instr >> nbits_o;
      mask = (64'd1 << opcode_w) - 64'd1;
      sh   = sh & mask;
      return sh[7:0];
   endfunction

endpackage

// File: rtl/bip_if.sv
// Load, run/step control and status bundle of the BIP processor system.
interface bip_if #(
   parameter int unsigned NBITS_O   = 11,
   parameter int unsigned NBITS_D   = 16,
   parameter int unsigned NBITS_CNT = 32
);
   logic                 i_load_en;
   logic [NBITS_O-1:0]   i_load_addr;
   logic [NBITS_D-1:0]   i_load_data;
   logic                 i_run;
   logic                 i_step;
   logic                 o_halt;
   logic                 o_busy;
   logic [NBITS_O-1:0]   o_pc;
   logic [NBITS_D-1:0]   o_acc;
   logic [NBITS_CNT-1:0] o_cycles;

   modport master (
      output i_load_en, i_load_addr, i_load_data, i_run, i_step,
      input  o_halt, o_busy, o_pc, o_acc, o_cycles
   );

   modport slave (
      input  i_load_en, i_load_addr, i_load_data, i_run, i_step,
      output o_halt, o_busy, o_pc, o_acc, o_cycles
   );
endinterface

// File: rtl/bip_core.sv
// Single-cycle BIP datapath: decodes one instruction and computes the next
// ACC/PC and the data-memory write strobe when fire is high.
module bip_core
   import bip_pkg::*;
#(
   parameter int unsigned NBITS_O   = 11,
   parameter int unsigned OPCODE    = 5,
   parameter int unsigned NBITS_D   = 16,
   parameter int unsigned PM_CELDAS = 64
) (
   input  logic               fire,
   input  logic [NBITS_D-1:0] instr,
   input  logic [NBITS_D-1:0] acc_q,
   input  logic [NBITS_O-1:0] pc_q,
   input  logic [NBITS_D-1:0] dm_rdata,
   output logic [NBITS_D-1:0] acc_d,
   output logic [NBITS_O-1:0] pc_d,
   output logic               dm_we,
   output logic               is_hlt
);

   logic [7:0]         opcode;
   logic [NBITS_O-1:0] operand;
   logic [NBITS_D-1:0] imm;
   logic [NBITS_O-1:0] pc_inc;

   always_comb begin
      opcode  = op_field(64'(instr), NBITS_O, OPCODE);
      operand = instr[NBITS_O-1:0];
      imm     = {{(NBITS_D-NBITS_O){operand[NBITS_O-1]}}, operand};
      pc_inc  = (pc_q == NBITS_O'(PM_CELDAS-1)) ? '0 : pc_q + 1'b1;

      acc_d  = acc_q;
      pc_d   = pc_q;
      dm_we  = 1'b0;
      is_hlt = 1'b0;

      if (fire) begin
         pc_d = pc_inc;
         unique case (opcode)
            OP_HLT: begin
               pc_d   = pc_q;
               is_hlt = 1'b1;
            end
            OP_STO:  dm_we = 1'b1;
            OP_LD:   acc_d = dm_rdata;
            OP_LDI:  acc_d = imm;
            OP_ADD:  acc_d = acc_q + dm_rdata;
            OP_ADDI: acc_d = acc_q + imm;
            OP_SUB:  acc_d = acc_q - dm_rdata;
            OP_SUBI: acc_d = acc_q - imm;
            OP_JMP:  pc_d  = operand;
            OP_BEQ:  if (acc_q == '0) pc_d = operand;
            OP_BNE:  if (acc_q != '0) pc_d = operand;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bip_system.sv
// BIP processor system: program/data memories, idle/run/halt control FSM,
// saturating executed-instruction counter around the bip_core datapath.
module bip_system
   import bip_pkg::*;
#(
   parameter int unsigned NBITS_O   = 11,
   parameter int unsigned OPCODE    = 5,
   parameter int unsigned NBITS_D   = 16,
   parameter int unsigned PM_CELDAS = 64,
   parameter int unsigned DM_CELDAS = 64,
   parameter int unsigned NBITS_CNT = 32
) (
   input  logic i_clk,
   input  logic i_reset,
   bip_if.slave bus
);

   localparam int unsigned PA_W = $clog2(PM_CELDAS);
   localparam int unsigned DA_W = $clog2(DM_CELDAS);

   logic [NBITS_D-1:0]   pm_q [PM_CELDAS];
   logic [NBITS_D-1:0]   dm_q [DM_CELDAS];

   state_e               state_q, state_d;
   logic [NBITS_D-1:0]   acc_q, acc_d;
   logic [NBITS_O-1:0]   pc_q, pc_d;
   logic [NBITS_CNT-1:0] cycles_q, cycles_d;
   logic                 busy_q, busy_d;
   logic                 halt_q, halt_d;

   logic [NBITS_D-1:0]   instr;
   logic [NBITS_D-1:0]   dm_rdata;
   logic [PA_W-1:0]      pc_addr;
   logic [PA_W-1:0]      load_addr;
   logic [DA_W-1:0]      dm_addr;
   logic                 load_ok;
   logic                 fire;
   logic                 dm_we;
   logic                 is_hlt;

   always_comb begin
      pc_addr   = PA_W'(pc_q);
      load_addr = PA_W'(bus.i_load_addr);
      instr     = pm_q[pc_addr];
      dm_addr   = DA_W'(instr);
      dm_rdata  = dm_q[dm_addr];
   end

   bip_core #(
      .NBITS_O   (NBITS_O),
      .OPCODE    (OPCODE),
      .NBITS_D   (NBITS_D),
      .PM_CELDAS (PM_CELDAS)
   ) u_core (
      .fire     (fire),
      .instr    (instr),
      .acc_q    (acc_q),
      .pc_q     (pc_q),
      .dm_rdata (dm_rdata),
      .acc_d    (acc_d),
      .pc_d     (pc_d),
      .dm_we    (dm_we),
      .is_hlt   (is_hlt)
   );

   // In IDLE a load masks run, and run masks step, within the same cycle.
   always_comb begin
      load_ok = 1'b0;
      fire    = 1'b0;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_load_en) begin
               load_ok = 1'b1;
            end else if (bus.i_run) begin
               state_d = ST_RUN;
            end else if (bus.i_step) begin
               fire = 1'b1;
               if (is_hlt) state_d = ST_HALT;
            end
         end
         ST_RUN: begin
            fire = 1'b1;
            if (is_hlt) state_d = ST_HALT;
         end
         default: state_d = ST_HALT;
      endcase

      cycles_d = (fire && (cycles_q != '1)) ? cycles_q + 1'b1 : cycles_q;
      busy_d   = (state_d == ST_RUN);
      halt_d   = (state_d == ST_HALT);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         pc_q     <= '0;
         cycles_q <= '0;
         busy_q   <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         pc_q     <= pc_d;
         cycles_q <= cycles_d;
         busy_q   <= busy_d;
         halt_q   <= halt_d;
      end
   end

   // Memories keep their contents across reset; writes are suppressed while reset is high.
   always_ff @(posedge i_clk) begin
      if (!i_reset && load_ok) pm_q[load_addr] <= bus.i_load_data;
      if (!i_reset && dm_we)   dm_q[dm_addr]   <= acc_q;
   end

   assign bus.o_halt   = halt_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_pc     = pc_q;
   assign bus.o_acc    = acc_q;
   assign bus.o_cycles = cycles_q;

endmodule
